// File: rtl/exception_sequencer.sv
// Multicycle exception controller: saves EPC, fetches the vector byte and reloads PC.
// Optional build macro EXC_MASK_EN adds a per-source request mask input (exc_mask_i).
module exception_sequencer #(
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF    = 32'd254,
    parameter logic [31:0] VEC_DIV0   = 32'd255,
    parameter int unsigned MEM_LAT    = 2
) (
    input  logic        clock,
    input  logic        reset,
`ifdef EXC_MASK_EN
    input  logic [2:0]  exc_mask_i,
`endif
    input  logic        bad_opcode_i,
    input  logic        ovf_i,
    input  logic        div0_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] mem_data_i,
    output logic        exc_busy_o,
    output logic [31:0] vec_addr_o,
    output logic [31:0] epc_o,
    output logic        epc_write_o,
    output logic [1:0]  cause_o,
    output logic        pc_load_o,
    output logic [31:0] pc_next_o,
    output logic        exc_done_o
);

    localparam int unsigned CNT_W   = 3;
    localparam int unsigned CAUSE_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_MEMRD,
        S_WAIT,
        S_LOADPC,
        S_DONE
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q;
    logic [31:0]          vec_addr_q;
    logic [31:0]          epc_q;
    logic                 epc_write_q;
    logic [CAUSE_W-1:0]   cause_q;
    logic                 pc_load_q;
    logic [31:0]          pc_next_q;
    logic                 exc_done_q;

    logic [2:0]           req_c;
    logic [CAUSE_W-1:0]   cause_d;
    logic [31:0]          vec_addr_d;
    logic [31:0]          epc_d;
    logic [31:0]          pc_next_d;
    logic                 unused_mem_hi_c;

    // Request vector ordered {div0, overflow, opcode}
`ifdef EXC_MASK_EN
    assign req_c = {div0_i, ovf_i, bad_opcode_i} & ~exc_mask_i;
`else
    assign req_c = {div0_i, ovf_i, bad_opcode_i};
`endif

    // Priority select: opcode > overflow > div0
    always_comb begin
        cause_d    = CAUSE_W'(0);
        vec_addr_d = 32'd0;
        if (req_c[0]) begin
            cause_d    = CAUSE_W'(1);
            vec_addr_d = VEC_OPCODE;
        end else if (req_c[1]) begin
            cause_d    = CAUSE_W'(2);
            vec_addr_d = VEC_OVF;
        end else if (req_c[2]) begin
            cause_d    = CAUSE_W'(3);
            vec_addr_d = VEC_DIV0;
        end
    end

    assign epc_d           = pc_i - 32'd4;
    assign pc_next_d       = {24'h0, mem_data_i[7:0]};
    assign unused_mem_hi_c = ^mem_data_i[31:8];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            vec_addr_q  <= 32'd0;
            epc_q       <= 32'd0;
            epc_write_q <= 1'b0;
            cause_q     <= '0;
            pc_load_q   <= 1'b0;
            pc_next_q   <= 32'd0;
            exc_done_q  <= 1'b0;
        end else begin
            epc_write_q <= 1'b0;
            pc_load_q   <= 1'b0;
            exc_done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|req_c) begin
                        state_q    <= S_SAVE;
                        busy_q     <= 1'b1;
                        cause_q    <= cause_d;
                        vec_addr_q <= vec_addr_d;
                    end
                end
                S_SAVE: begin
                    epc_q       <= epc_d;
                    epc_write_q <= 1'b1;
                    state_q     <= S_MEMRD;
                end
                S_MEMRD: begin
                    cnt_q   <= CNT_W'(MEM_LAT - 1);
                    state_q <= S_WAIT;
                end
                // Stays MEM_LAT cycles: counter runs MEM_LAT-1 down to 0
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_LOADPC;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                // Data and strobe are registered together so they appear in DONE
                S_LOADPC: begin
                    pc_next_q  <= pc_next_d;
                    pc_load_q  <= 1'b1;
                    exc_done_q <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign exc_busy_o  = busy_q;
    assign vec_addr_o  = vec_addr_q;
    assign epc_o       = epc_q;
    assign epc_write_o = epc_write_q;
    assign cause_o     = cause_q;
    assign pc_load_o   = pc_load_q;
    assign pc_next_o   = pc_next_q;
    assign exc_done_o  = exc_done_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed self-checking bench for exception_sequencer (MEM_LAT=2).
module tb_exception_sequencer;

    logic        clock;
    logic        reset;
    logic        bad_opcode_i;
    logic        ovf_i;
    logic        div0_i;
    logic [31:0] pc_i;
    logic [31:0] mem_data_i;
    logic        exc_busy_o;
    logic [31:0] vec_addr_o;
    logic [31:0] epc_o;
    logic        epc_write_o;
    logic [1:0]  cause_o;
    logic        pc_load_o;
    logic [31:0] pc_next_o;
    logic        exc_done_o;
`ifdef EXC_MASK_EN
    logic [2:0]  exc_mask_i;
`endif

    int total;
    int bad;

    exception_sequencer #(
        .VEC_OPCODE(32'd253),
        .VEC_OVF   (32'd254),
        .VEC_DIV0  (32'd255),
        .MEM_LAT   (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
`ifdef EXC_MASK_EN
        .exc_mask_i  (exc_mask_i),
`endif
        .bad_opcode_i(bad_opcode_i),
        .ovf_i       (ovf_i),
        .div0_i      (div0_i),
        .pc_i        (pc_i),
        .mem_data_i  (mem_data_i),
        .exc_busy_o  (exc_busy_o),
        .vec_addr_o  (vec_addr_o),
        .epc_o       (epc_o),
        .epc_write_o (epc_write_o),
        .cause_o     (cause_o),
        .pc_load_o   (pc_load_o),
        .pc_next_o   (pc_next_o),
        .exc_done_o  (exc_done_o)
    );

    always #5 clock = ~clock;

    // Vector memory: upper bytes are junk that must be dropped
    always_comb begin
        case (vec_addr_o)
            32'd253: mem_data_i = 32'hABCD_EF5A;
            32'd254: mem_data_i = 32'h1234_568C;
            32'd255: mem_data_i = 32'hFFFF_FF20;
            default: mem_data_i = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // mode 0: request one cycle; 1: plus ovf re-asserted in WAIT; 2: request held throughout
    task automatic run_seq(input logic [31:0] pc, input logic [2:0] req, input int mode,
                           input logic [31:0] exp_vec, input logic [1:0] exp_cause,
                           input logic [31:0] exp_epc, input logic [31:0] exp_pcn);
        int busy_cnt;
        pc_i         = pc;
        div0_i       = req[2];
        ovf_i        = req[1];
        bad_opcode_i = req[0];
        tick();
        check("start_busy", 32'(exc_busy_o), 32'd1);
        check("start_vec", vec_addr_o, exp_vec);
        check("start_cause", 32'(cause_o), 32'(exp_cause));
        check("start_epcw", 32'(epc_write_o), 32'd0);
        busy_cnt = 1;
        if (mode != 2) begin
            div0_i = 1'b0; ovf_i = 1'b0; bad_opcode_i = 1'b0;
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (mode == 1 && k == 2) ovf_i = 1'b1;
            if (mode == 1 && k == 4) ovf_i = 1'b0;
            if (exc_busy_o) busy_cnt++;
            check("epc", epc_o, exp_epc);
            check("epc_write", 32'(epc_write_o), (k == 1) ? 32'd1 : 32'd0);
            check("pc_load", 32'(pc_load_o), (k == 5) ? 32'd1 : 32'd0);
            check("exc_done", 32'(exc_done_o), (k == 5) ? 32'd1 : 32'd0);
            check("vec_hold", vec_addr_o, exp_vec);
            if (k == 5) check("pc_next", pc_next_o, exp_pcn);
            if (k == 6) check("cause_hold", 32'(cause_o), 32'(exp_cause));
        end
        check("busy_cycles", 32'(busy_cnt), 32'd6);
        tick();
        check("restart_busy", 32'(exc_busy_o), (mode == 2) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int n;
        total = 0;
        bad = 0;
        clock = 1'b0;
        reset = 1'b1;
        bad_opcode_i = 1'b0;
        ovf_i = 1'b0;
        div0_i = 1'b0;
        pc_i = 32'd0;
`ifdef EXC_MASK_EN
        exc_mask_i = 3'b000;
`endif
        tick();
        tick();
        check("rst_busy", 32'(exc_busy_o), 32'd0);
        check("rst_vec", vec_addr_o, 32'd0);
        check("rst_epc", epc_o, 32'd0);
        check("rst_cause", 32'(cause_o), 32'd0);
        check("rst_pcnext", pc_next_o, 32'd0);
        check("rst_pulses", {29'd0, epc_write_o, pc_load_o, exc_done_o}, 32'd0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(exc_busy_o), 32'd0);

        // Overflow: EPC 0x40-4, vector byte 0x8C
        run_seq(32'h40, 3'b010, 0, 32'd254, 2'd2, 32'h3C, 32'h8C);
        // Opcode beats div0
        run_seq(32'h10, 3'b101, 0, 32'd253, 2'd1, 32'hC, 32'h5A);
        // EPC wrap
        run_seq(32'h0, 3'b100, 0, 32'd255, 2'd3, 32'hFFFF_FFFC, 32'h20);
        // Overflow re-asserted mid-sequence is ignored
        run_seq(32'h200, 3'b010, 1, 32'd254, 2'd2, 32'h1FC, 32'h8C);
        // Overflow held through DONE restarts right after
        run_seq(32'h300, 3'b010, 2, 32'd254, 2'd2, 32'h2FC, 32'h8C);
        ovf_i = 1'b0;
        n = 0;
        while (exc_busy_o && n < 20) begin
            tick();
            n++;
        end
        check("second_seq_ends", 32'(exc_busy_o), 32'd0);
        tick();

        // Reset while in WAIT
        pc_i = 32'h80;
        div0_i = 1'b1;
        tick();
        div0_i = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", 32'(exc_busy_o), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", 32'(exc_busy_o), 32'd0);
        check("midrst_epc", epc_o, 32'd0);
        check("midrst_cause", 32'(cause_o), 32'd0);
        for (int k = 0; k < 6; k++) begin
            check("midrst_noload", 32'(pc_load_o), 32'd0);
            tick();
        end

`ifdef EXC_MASK_EN
        exc_mask_i = 3'b010;
        run_seq(32'h40, 3'b110, 0, 32'd255, 2'd3, 32'h3C, 32'h20);
        exc_mask_i = 3'b000;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
